// File: rtl/s_term_single_cfg_switch_matrix.sv
// South-edge terminal switch matrix: loops southbound wires back north with index reversal,
// with per-group run-time modes loaded by a serial shadow/commit frame. Optional: S_TERM_CFG_PARITY_EN.

module s_term_wire_group #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   mode,
   input  logic [W-1:0] in_w,
   output logic [W-1:0] out_w
);
   localparam logic [1:0] M_PASS = 2'b00;
   localparam logic [1:0] M_REG  = 2'b01;
   localparam logic [1:0] M_ZERO = 2'b10;

   logic [W-1:0] rev;
   logic [W-1:0] cap_d, cap_q;

   always_comb begin
      rev = '0;
      for (int i = 0; i < W; i++) rev[i] = in_w[W-1-i];
   end

   // The capture register only freezes in HOLD, so entering HOLD keeps the last captured value.
   always_comb begin
      cap_d = (mode == 2'b11) ? cap_q : rev;
   end

   always_ff @(posedge clk) begin
      if (rst) cap_q <= '0;
      else     cap_q <= cap_d;
   end

   always_comb begin
      case (mode)
         M_PASS:  out_w = rev;
         M_REG:   out_w = cap_q;
         M_ZERO:  out_w = '0;
         default: out_w = cap_q;
      endcase
   end
endmodule

module s_term_single_cfg_switch_matrix #(
   parameter int FRAME_BITS = 16
) (
   input  logic        UserCLK,
   input  logic        rst,
   input  logic [3:0]  S1END,
   input  logic [7:0]  S2MID,
   input  logic [7:0]  S2END,
   input  logic [15:0] S4END,
   input  logic [15:0] SS4END,
   output logic [3:0]  N1BEG,
   output logic [7:0]  N2BEG,
   output logic [7:0]  N2BEGb,
   output logic [15:0] N4BEG,
   output logic [15:0] NN4BEG,
   output logic        Co0,
   input  logic        cfg_shift_en,
   input  logic        cfg_bit_in,
   input  logic        cfg_commit,
   input  logic        cfg_err_clr,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic        cfg_full,
   output logic [1:0]  cfg_state
);
`ifdef S_TERM_CFG_PARITY_EN
   localparam int SW = FRAME_BITS + 1;
`else
   localparam int SW = FRAME_BITS;
`endif
   localparam logic [4:0] FULL_CNT = 5'(SW);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_FULL = 2'd2} state_t;

   state_t          state_d, state_q;
   logic [4:0]      count_d, count_q;
   logic [SW-1:0]   shadow_d, shadow_q;
   logic [15:0]     active_d, active_q;
   logic            done_d, done_q;
   logic            err_d, err_q;
   logic            parity_ok;
   logic [9:0]      mode_eff;
   logic            unused_rsvd;

`ifdef S_TERM_CFG_PARITY_EN
   assign parity_ok = ~^shadow_q;
`else
   assign parity_ok = 1'b1;
`endif

   // Commit wins over a same-cycle shift; the dropped bit is flagged as an error.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shadow_d = shadow_q;
      active_d = active_q;
      done_d   = 1'b0;
      err_d    = err_q;
      if (cfg_err_clr) err_d = 1'b0;
      if (cfg_commit) begin
         if (cfg_shift_en) err_d = 1'b1;
         if (state_q == ST_FULL && parity_ok) begin
            active_d = shadow_q[SW-1 -: 16];
            done_d   = 1'b1;
         end else begin
            err_d = 1'b1;
         end
         state_d = ST_IDLE;
         count_d = '0;
      end else if (cfg_shift_en) begin
         shadow_d = {shadow_q[SW-2:0], cfg_bit_in};
         if (count_q != 5'h1f) count_d = count_q + 5'd1;
         if (state_q == ST_FULL)                  err_d   = 1'b1;
         else if (count_q + 5'd1 == FULL_CNT)     state_d = ST_FULL;
         else                                     state_d = ST_SHIFT;
      end
   end

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Wires stay in pass-through while reset is held, whatever the config flops hold.
   assign mode_eff    = rst ? 10'd0 : active_q[9:0];
   assign Co0         = active_q[10];
   assign cfg_done    = done_q;
   assign cfg_err     = err_q;
   assign cfg_full    = (state_q == ST_FULL);
   assign cfg_state   = state_q;
   assign unused_rsvd = ^active_q[15:11];

   s_term_wire_group #(.W(4))  u_n1  (.clk(UserCLK), .rst(rst), .mode(mode_eff[1:0]), .in_w(S1END),  .out_w(N1BEG));
   s_term_wire_group #(.W(8))  u_n2  (.clk(UserCLK), .rst(rst), .mode(mode_eff[3:2]), .in_w(S2MID),  .out_w(N2BEG));
   s_term_wire_group #(.W(8))  u_n2b (.clk(UserCLK), .rst(rst), .mode(mode_eff[5:4]), .in_w(S2END),  .out_w(N2BEGb));
   s_term_wire_group #(.W(16)) u_n4  (.clk(UserCLK), .rst(rst), .mode(mode_eff[7:6]), .in_w(S4END),  .out_w(N4BEG));
   s_term_wire_group #(.W(16)) u_nn4 (.clk(UserCLK), .rst(rst), .mode(mode_eff[9:8]), .in_w(SS4END), .out_w(NN4BEG));
endmodule

// File: tb/tb_s_term_single_cfg_switch_matrix.sv
// Directed bench for s_term_single_cfg_switch_matrix; builds with or without S_TERM_CFG_PARITY_EN.

module tb_s_term_single_cfg_switch_matrix;
  logic        UserCLK = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  S1END = '0;
  logic [7:0]  S2MID = '0;
  logic [7:0]  S2END = '0;
  logic [15:0] S4END = '0;
  logic [15:0] SS4END = '0;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG;
  logic [7:0]  N2BEGb;
  logic [15:0] N4BEG;
  logic [15:0] NN4BEG;
  logic        Co0;
  logic        cfg_shift_en = 1'b0;
  logic        cfg_bit_in = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        cfg_err_clr = 1'b0;
  logic        cfg_done;
  logic        cfg_err;
  logic        cfg_full;
  logic [1:0]  cfg_state;

`ifdef S_TERM_CFG_PARITY_EN
  localparam int FL = 17;
`else
  localparam int FL = 16;
`endif
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] hold_val;

  s_term_single_cfg_switch_matrix dut (
    .UserCLK(UserCLK), .rst(rst), .S1END(S1END), .S2MID(S2MID), .S2END(S2END),
    .S4END(S4END), .SS4END(SS4END), .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb),
    .N4BEG(N4BEG), .NN4BEG(NN4BEG), .Co0(Co0), .cfg_shift_en(cfg_shift_en),
    .cfg_bit_in(cfg_bit_in), .cfg_commit(cfg_commit), .cfg_err_clr(cfg_err_clr),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_full(cfg_full), .cfg_state(cfg_state)
  );

  // clock / reset
  always #5 UserCLK = ~UserCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  function automatic logic [31:0] frame(input logic [15:0] d);
`ifdef S_TERM_CFG_PARITY_EN
    return {15'd0, d, ^d};
`else
    return {16'd0, d};
`endif
  endfunction

  // driver tasks: inputs change just after the falling edge, outputs sampled there too
  task automatic tick();
    @(negedge UserCLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_shift_en = 1'b1;
      cfg_bit_in   = bits[i];
      tick();
    end
    cfg_shift_en = 1'b0;
    cfg_bit_in   = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic err_clear();
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset and pass-through
    S4END = 16'h0001;
    settle();
    check("n4_pass_in_reset", N4BEG, 16'h8000);
    tick(); tick();
    rst = 1'b0;
    S1END = 4'(  $urandom_range(0, 15));
    S2END = 8'(  $urandom_range(0, 255));
    SS4END = 16'($urandom_range(0, 65535));
    settle();
    check("n4_pass", N4BEG, 16'h8000);
    check("n1_pass", N1BEG, rev(16'(S1END), 4));
    check("n2b_pass", N2BEGb, rev(16'(S2END), 8));
    check("nn4_pass", NN4BEG, rev(SS4END, 16));
    check("co0_reset", Co0, 0);
    check("err_reset", cfg_err, 0);
    check("done_reset", cfg_done, 0);
    check("full_reset", cfg_full, 0);
    check("state_reset", cfg_state, S_IDLE);

    // N2 into REG mode, one-cycle latency through scoreboard
    shift_bits(frame(16'h0004), FL);
    check("full_after_frame", cfg_full, 1);
    commit();
    check("done_pulse", cfg_done, 1);
    check("state_after_commit", cfg_state, S_IDLE);
    S2MID = 8'h01;
    exp_q.push_back(16'h0080);
    tick();
    check("done_one_cycle", cfg_done, 0);
    check("n2_reg_1", N2BEG, exp_q.pop_front());
    S2MID = 8'h02;
    exp_q.push_back(16'h0040);
    tick();
    check("n2_reg_2", N2BEG, exp_q.pop_front());
    S2END = 8'h0f;
    settle();
    check("n2b_still_pass", N2BEGb, 16'h00f0);

    // Co0 high with N4 forced low, then NN4 HOLD
    shift_bits(frame(16'h0480), FL);
    commit();
    S4END = 16'hffff;
    settle();
    check("co0_set", Co0, 1);
    check("n4_zero", N4BEG, 0);
    SS4END = 16'h00f0;
    shift_bits(frame(16'h0300), FL);
    commit();
    hold_val = rev(16'h00f0, 16);
    check("co0_clear", Co0, 0);
    for (int k = 0; k < 3; k++) begin
      SS4END = 16'($urandom_range(0, 65535));
      settle();
      check("nn4_hold", NN4BEG, hold_val);
      tick();
    end
    settle();
    check("n4_back_pass", N4BEG, 16'hffff);

    // short frame commit is rejected
    shift_bits(32'h3ff, 10);
    commit();
    check("short_err", cfg_err, 1);
    check("short_no_done", cfg_done, 0);
    SS4END = 16'h1234;
    settle();
    check("short_active_kept", NN4BEG, hold_val);
    err_clear();
    check("err_cleared", cfg_err, 0);

    // over-long frame: last FL bits win, error flagged
    shift_bits({2'b11, frame(16'h0400)[29:0]}, FL + 2);
    commit();
    check("long_err", cfg_err, 1);
    check("long_done", cfg_done, 1);
    check("long_co0", Co0, 1);
    check("long_nn4_pass", NN4BEG, rev(SS4END, 16));
    err_clear();

    // shift and commit together: commit accepted, bit dropped, error flagged
    S1END = 4'b0001;
    shift_bits(frame(16'h0000), FL);
    cfg_shift_en = 1'b1;
    cfg_bit_in   = 1'b1;
    cfg_commit   = 1'b1;
    tick();
    cfg_shift_en = 1'b0;
    cfg_bit_in   = 1'b0;
    cfg_commit   = 1'b0;
    S1END = 4'b0011;
    settle();
    check("both_done", cfg_done, 1);
    check("both_err", cfg_err, 1);
    check("both_co0", Co0, 0);
    check("both_bit_dropped", N1BEG, 4'b1100);
    err_clear();

    // reset in the middle of a frame
    shift_bits(frame(16'h03ff), FL);
    commit();
    shift_bits(32'ha5, 8);
    check("mid_shift_state", cfg_state, S_SHIFT);
    rst = 1'b1;
    S1END = 4'b0010;
    settle();
    check("n1_pass_during_rst", N1BEG, 4'b0100);
    tick();
    rst = 1'b0;
    S4END = 16'h0f01;
    settle();
    check("rst_state", cfg_state, S_IDLE);
    check("rst_full", cfg_full, 0);
    check("rst_n4_pass", N4BEG, rev(16'h0f01, 16));
    check("rst_nn4_pass", NN4BEG, rev(SS4END, 16));
    shift_bits(32'h0, FL - 1);
    check("rst_count_not_full", cfg_full, 0);
    shift_bits(32'h0, 1);
    check("rst_count_full", cfg_full, 1);
    commit();
    check("rst_recommit_done", cfg_done, 1);

`ifdef S_TERM_CFG_PARITY_EN
    // bad parity bit rejects the frame
    tick();
    shift_bits({15'd0, 16'h0400, 1'b0}, FL);
    commit();
    check("parity_err", cfg_err, 1);
    check("parity_no_done", cfg_done, 0);
    check("parity_co0_kept", Co0, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
